// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer.
// Memory op encoding matches the data memory's 2-bit WE port.
// Entry addresses are stored zero-extended from the memory's ADDRESS_WIDTH bits.
package sb_pkg;

  localparam logic [1:0] MEM_LW = 2'b00;
  localparam logic [1:0] MEM_SW = 2'b01;
  localparam logic [1:0] MEM_LB = 2'b10;
  localparam logic [1:0] MEM_SB = 2'b11;

  typedef struct packed {
    logic        is_byte;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  function automatic logic [31:0] sext_byte(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  // Big-endian byte lane select: offset 0 is the most significant byte.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    unique case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Combinational load-vs-buffer search.
// Ports: entries/head/count describe the live FIFO contents; ld_byte/ld_key describe the load
// (ld_key already masked to the memory address width). hit/fwd_data give a forwardable value,
// hazard flags an lw whose newest overlapping entry is a byte store.
module store_buffer_match
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  sb_entry_t                entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic                     ld_byte,
  input  logic [31:0]              ld_key,
  output logic                     hit,
  output logic                     hazard,
  output logic [31:0]              fwd_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] idx;
  sb_entry_t       e;

  // Walk oldest to newest; later overlaps overwrite earlier ones, so the newest wins.
  always_comb begin
    hit      = 1'b0;
    hazard   = 1'b0;
    fwd_data = '0;
    idx      = head;
    e        = entries[head];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PtrW'(i);
      e   = entries[idx];
      if (((PtrW + 1)'(i) < count) && (e.addr[31:2] == ld_key[31:2])) begin
        if (!ld_byte) begin
          hit      = !e.is_byte;
          hazard   = e.is_byte;
          fwd_data = e.is_byte ? 32'h0 : e.data;
        end else if (!e.is_byte) begin
          hit      = 1'b1;
          hazard   = 1'b0;
          fwd_data = sext_byte(pick_byte(e.data, ld_key[1:0]));
        end else if (e.addr[1:0] == ld_key[1:0]) begin
          hit      = 1'b1;
          hazard   = 1'b0;
          fwd_data = sext_byte(e.data[7:0]);
        end
        // sb in the same word but another byte does not overlap an lb: keep previous result.
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer owning the single data-memory port.
// Ports: st_* store request/ready from the core; ld_* load request, combinational result and
// stall; empty for fence; mem_WE/mem_A/mem_WD/mem_RD drive the byte-addressed data memory.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ADDRESS_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic        st_byte,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic        ld_byte,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_rdata,
  output logic        ld_stall,
  output logic        empty,
  output logic [1:0]  mem_WE,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] AddrMask = (ADDRESS_WIDTH >= 32) ? 32'hFFFF_FFFF :
                                     32'((64'd1 << ADDRESS_WIDTH) - 64'd1);

  sb_entry_t       entries_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  sb_entry_t   new_entry, head_entry;
  logic [31:0] st_key, ld_key, fwd_data;
  logic        push, pop, full, hit, hazard;

  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);
  assign st_ready   = !full;
  assign push       = st_valid && st_ready;
  assign head_entry = entries_q[head_q];

  assign st_key = st_addr & AddrMask;
  assign ld_key = ld_addr & AddrMask;

  always_comb begin
    new_entry.is_byte = st_byte;
    new_entry.addr    = st_byte ? st_key : {st_key[31:2], 2'b00};
    new_entry.data    = st_byte ? {24'h0, st_data[7:0]} : st_data;
  end

  store_buffer_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .entries  (entries_q),
    .head     (head_q),
    .count    (count_q),
    .ld_byte  (ld_byte),
    .ld_key   (ld_key),
    .hit      (hit),
    .hazard   (hazard),
    .fwd_data (fwd_data)
  );

  // Port arbitration: an unforwardable, hazard-free load owns the port; otherwise drain.
  always_comb begin
    ld_rdata = '0;
    ld_stall = 1'b0;
    mem_WE   = MEM_LW;
    mem_A    = '0;
    mem_WD   = '0;
    pop      = 1'b0;
    if (ld_valid && hit) begin
      ld_rdata = fwd_data;
      pop      = !empty;
    end else if (ld_valid && (hazard || full)) begin
      ld_stall = 1'b1;
      pop      = !empty;
    end else if (ld_valid) begin
      mem_WE   = ld_byte ? MEM_LB : MEM_LW;
      mem_A    = ld_byte ? ld_addr : {ld_addr[31:2], 2'b00};
      ld_rdata = mem_RD;
    end else begin
      pop = !empty;
    end
    if (pop) begin
      mem_WE = head_entry.is_byte ? MEM_SB : MEM_SW;
      mem_A  = head_entry.addr;
      mem_WD = head_entry.data;
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: count gates every use.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[tail_q] <= new_entry;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import sb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_byte, st_ready;
  logic [31:0] st_addr, st_data;
  logic        ld_valid, ld_byte, ld_stall, empty;
  logic [31:0] ld_addr, ld_rdata;
  logic [1:0]  mem_WE;
  logic [31:0] mem_A, mem_WD, mem_RD;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH         (DEPTH),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_byte  (st_byte),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_addr  (ld_addr),
    .ld_rdata (ld_rdata),
    .ld_stall (ld_stall),
    .empty    (empty),
    .mem_WE   (mem_WE),
    .mem_A    (mem_A),
    .mem_WD   (mem_WD),
    .mem_RD   (mem_RD)
  );

  // Big-endian byte-addressed memory model.
  logic [7:0] mem [0:1023];
  logic [9:0] ra;

  always_comb begin
    ra = mem_A[9:0];
    if (mem_WE == MEM_LB) mem_RD = {{24{mem[ra][7]}}, mem[ra]};
    else mem_RD = {mem[ra], mem[ra + 10'd1], mem[ra + 10'd2], mem[ra + 10'd3]};
  end

  always @(posedge clk) begin
    if (mem_WE == MEM_SW) begin
      mem[mem_A[9:0]]         <= mem_WD[31:24];
      mem[mem_A[9:0] + 10'd1] <= mem_WD[23:16];
      mem[mem_A[9:0] + 10'd2] <= mem_WD[15:8];
      mem[mem_A[9:0] + 10'd3] <= mem_WD[7:0];
    end else if (mem_WE == MEM_SB) begin
      mem[mem_A[9:0]] <= mem_WD[7:0];
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total  = 0;
  int  passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: every memory write must match the oldest outstanding store.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n && (mem_WE == MEM_SW || mem_WE == MEM_SB)) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected_op", {30'h0, mem_WE}, 32'h0);
      end else begin
        w = exp_q.pop_front();
        check("wr_op",   {30'h0, mem_WE}, {30'h0, w.op});
        check("wr_addr", mem_A, w.addr);
        check("wr_data", mem_WD, w.data);
      end
    end
  end

  task automatic set_idle();
    st_valid = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic store(input logic b, input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    st_valid = 1'b1;
    st_byte  = b;
    st_addr  = a;
    st_data  = d;
    w.op   = b ? MEM_SB : MEM_SW;
    w.addr = b ? (a & 32'h3FF) : (a & 32'h3FC);
    w.data = b ? {24'h0, d[7:0]} : d;
    exp_q.push_back(w);
  endtask

  task automatic load(input logic b, input logic [31:0] a);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_addr  = a;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (!empty && n < budget) begin
      next();
      n++;
    end
    check("drain_to_empty", {31'h0, empty}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst_n   = 1'b0;
    st_byte = 1'b0;
    st_addr = '0;
    st_data = '0;
    ld_byte = 1'b0;
    ld_addr = '0;
    set_idle();
    #12;
    check("rst_empty",    {31'h0, empty}, 32'h1);
    check("rst_st_ready", {31'h0, st_ready}, 32'h1);
    check("rst_ld_stall", {31'h0, ld_stall}, 32'h0);
    check("rst_ld_rdata", ld_rdata, 32'h0);
    check("rst_mem_WE",   {30'h0, mem_WE}, 32'h0);
    check("rst_mem_A",    mem_A, 32'h0);
    check("rst_mem_WD",   mem_WD, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Simple store then drain.
    next(); store(1'b0, 32'h10, 32'hDEADBEEF); settle();
    check("sw_ready", {31'h0, st_ready}, 32'h1);
    next(); settle();
    check("drain_WE", {30'h0, mem_WE}, {30'h0, MEM_SW});
    check("drain_A",  mem_A, 32'h10);
    check("drain_WD", mem_WD, 32'hDEADBEEF);
    next(); settle();
    check("drained_empty", {31'h0, empty}, 32'h1);
    load(1'b0, 32'h10); settle();
    check("lw_mem_WE", {30'h0, mem_WE}, {30'h0, MEM_LW});
    check("lw_mem_rd", ld_rdata, 32'hDEADBEEF);

    // Word forwarding; concurrent non-matching loads keep stores buffered.
    next(); store(1'b0, 32'h20, 32'h11223344); load(1'b0, 32'h200); settle();
    next(); store(1'b0, 32'h24, 32'h81AABBCC); load(1'b0, 32'h200); settle();
    next(); load(1'b0, 32'h20); settle();
    check("fwd_lw",       ld_rdata, 32'h11223344);
    check("fwd_lw_stall", {31'h0, ld_stall}, 32'h0);
    check("fwd_lw_drainA", mem_A, 32'h20);
    next(); load(1'b1, 32'h24); settle();
    check("fwd_lb_word_o0", ld_rdata, 32'hFFFFFF81);
    next(); load(1'b1, 32'h23); settle();
    check("lb_mem_WE", {30'h0, mem_WE}, {30'h0, MEM_LB});
    check("lb_mem_rd", ld_rdata, 32'h00000044);
    next(); store(1'b0, 32'h2C, 32'h000000A5); load(1'b0, 32'h200); settle();
    next(); load(1'b1, 32'h2F); settle();
    check("fwd_lb_word_o3", ld_rdata, 32'hFFFFFFA5);

    // Byte forwarding and lw-vs-sb hazard.
    next(); store(1'b1, 32'h31, 32'h000000F0); load(1'b0, 32'h200); settle();
    next(); store(1'b1, 32'h32, 32'h0000000F); load(1'b0, 32'h200); settle();
    next(); load(1'b1, 32'h31); settle();
    check("fwd_lb_sb",    ld_rdata, 32'hFFFFFFF0);
    check("sb_drain_WE",  {30'h0, mem_WE}, {30'h0, MEM_SB});
    next(); load(1'b0, 32'h30); settle();
    check("hazard_stall", {31'h0, ld_stall}, 32'h1);
    check("hazard_rdata", ld_rdata, 32'h0);
    check("hazard_drainA", mem_A, 32'h32);
    next(); load(1'b0, 32'h30); settle();
    check("after_hz_stall", {31'h0, ld_stall}, 32'h0);
    check("after_hz_WE",    {30'h0, mem_WE}, {30'h0, MEM_LW});
    check("after_hz_rdata", ld_rdata, 32'h00F00F00);

    // Fill the buffer, stall on full, then wrap the pointers.
    for (int i = 0; i < 4; i++) begin
      next(); store(1'b0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i)); load(1'b0, 32'h200); settle();
      check("fill_ready", {31'h0, st_ready}, 32'h1);
      check("fill_stall", {31'h0, ld_stall}, 32'h0);
    end
    next(); load(1'b0, 32'h200); settle();
    check("full_ready",  {31'h0, st_ready}, 32'h0);
    check("full_stall",  {31'h0, ld_stall}, 32'h1);
    check("full_drainA", mem_A, 32'h100);
    next(); load(1'b0, 32'h200); settle();
    check("unfull_ready", {31'h0, st_ready}, 32'h1);
    check("unfull_stall", {31'h0, ld_stall}, 32'h0);
    next(); store(1'b0, 32'h110, 32'hA4); settle();
    check("wrap_ready", {31'h0, st_ready}, 32'h1);
    next(); load(1'b0, 32'h110); settle();
    check("wrap_fwd",    ld_rdata, 32'hA4);
    check("wrap_drainA", mem_A, 32'h108);
    next();
    wait_empty(10);

    // Newest store wins; memory sees writes in order.
    next(); store(1'b0, 32'h40, 32'h1); load(1'b0, 32'h200); settle();
    next(); store(1'b0, 32'h40, 32'h2); load(1'b0, 32'h200); settle();
    next(); load(1'b0, 32'h40); settle();
    check("newest_wins", ld_rdata, 32'h2);
    next();
    wait_empty(10);
    next(); load(1'b0, 32'h40); settle();
    check("order_mem", ld_rdata, 32'h2);

    // Asynchronous reset with stores still buffered.
    next(); store(1'b0, 32'h60, 32'h7); load(1'b0, 32'h200); settle();
    next(); store(1'b0, 32'h64, 32'h8); load(1'b0, 32'h200); settle();
    next(); store(1'b0, 32'h68, 32'h9); load(1'b0, 32'h200); settle();
    next(); settle();
    check("pre_rst_busy", {31'h0, empty}, 32'h0);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_empty", {31'h0, empty}, 32'h1);
    check("async_rst_ready", {31'h0, st_ready}, 32'h1);
    check("async_rst_WE",    {30'h0, mem_WE}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next(); load(1'b0, 32'h60); settle();
    check("post_rst_WE",    {30'h0, mem_WE}, {30'h0, MEM_LW});
    check("post_rst_rdata", ld_rdata, 32'h0);
    next(); settle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
